mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a byte-wide synchronous RAM.
// Multi-byte accesses are serialised little-endian; the data port has priority.
module mem_arbiter #(
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [15:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic [15:0] ram_addr,
  output logic        ram_wren,
  output logic        ram_rden,
  output logic [7:0]  ram_data,
  input  logic [7:0]  ram_q,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;

  state_t      state, next_state;
  logic        lat_port, lat_we, lat_err;
  logic [15:0] lat_addr;
  logic [2:0]  lat_n;
  logic [31:0] lat_wdata;
  logic [2:0]  issue_cnt, cap_cnt;
  logic [2:0]  ret_vld;
  logic [31:0] rbuf;

  logic        grant, bad_size, issuing, cap_now, cap_last;
  logic        eff_port, eff_we, eff_err;
  logic [15:0] eff_addr;
  logic [2:0]  eff_n, req_n;
  logic [31:0] eff_wdata, rdata_new;
  logic [7:0]  wbyte;

  logic        if_ack_nxt, d_ack_nxt, d_err_nxt, busy_nxt, ram_wren_nxt, ram_rden_nxt;
  logic [15:0] ram_addr_nxt;
  logic [7:0]  ram_data_nxt;
  logic [31:0] if_rdata_nxt, d_rdata_nxt;

  // In IDLE the first byte is issued from the live request, afterwards from the latched copy
  always_comb begin
    grant    = (state == IDLE) && (d_req || if_req);
    bad_size = d_req && (d_size == 2'b11);
    req_n    = 3'd4;
    if (d_req) begin
      case (d_size)
        2'b00:   req_n = 3'd1;
        2'b01:   req_n = 3'd2;
        default: req_n = 3'd4;
      endcase
    end
    eff_port  = grant ? d_req                       : lat_port;
    eff_addr  = grant ? (d_req ? d_addr : if_addr)  : lat_addr;
    eff_we    = grant ? (d_req && d_we)             : lat_we;
    eff_wdata = grant ? d_wdata                     : lat_wdata;
    eff_err   = grant ? bad_size                    : lat_err;
    eff_n     = grant ? req_n                       : lat_n;
    issuing   = (grant && !bad_size) ||
                (((state == READ) || (state == WRITE)) && (issue_cnt < lat_n));
    cap_now   = (state == READ) && ret_vld[RD_LATENCY-1];
    cap_last  = cap_now && (cap_cnt == lat_n - 3'd1);
    rdata_new = rbuf | ({24'd0, ram_q} << {cap_cnt[1:0], 3'b000});
    case (issue_cnt[1:0])
      2'd0:    wbyte = eff_wdata[7:0];
      2'd1:    wbyte = eff_wdata[15:8];
      2'd2:    wbyte = eff_wdata[23:16];
      default: wbyte = eff_wdata[31:24];
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant) next_state = bad_size ? ACK : (eff_we ? WRITE : READ);
      READ:    if (cap_last) next_state = ACK;
      WRITE:   if (issue_cnt == lat_n) next_state = ACK;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_nxt     = (next_state != IDLE);
    if_ack_nxt   = (next_state == ACK) && !eff_port;
    d_ack_nxt    = (next_state == ACK) && eff_port;
    d_err_nxt    = (next_state == ACK) && eff_err;
    ram_rden_nxt = issuing && !eff_we;
    ram_wren_nxt = issuing && eff_we;
    ram_addr_nxt = issuing ? eff_addr + {13'd0, issue_cnt} : ram_addr;
    ram_data_nxt = (issuing && eff_we) ? wbyte : ram_data;
    if_rdata_nxt = (cap_last && !lat_port) ? rdata_new : if_rdata;
    d_rdata_nxt  = (cap_last && lat_port)  ? rdata_new : d_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      issue_cnt <= 3'd0;
      cap_cnt   <= 3'd0;
      ret_vld   <= 3'd0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      busy      <= 1'b0;
      ram_wren  <= 1'b0;
      ram_rden  <= 1'b0;
      ram_addr  <= 16'd0;
      ram_data  <= 8'd0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
    end else begin
      state    <= next_state;
      ret_vld  <= {ret_vld[1:0], ram_rden};
      if (issuing)             issue_cnt <= issue_cnt + 3'd1;
      else if (state == ACK)   issue_cnt <= 3'd0;
      if (cap_now)             cap_cnt <= cap_cnt + 3'd1;
      else if (state == ACK)   cap_cnt <= 3'd0;
      if_ack   <= if_ack_nxt;
      d_ack    <= d_ack_nxt;
      d_err    <= d_err_nxt;
      busy     <= busy_nxt;
      ram_wren <= ram_wren_nxt;
      ram_rden <= ram_rden_nxt;
      ram_addr <= ram_addr_nxt;
      ram_data <= ram_data_nxt;
      if_rdata <= if_rdata_nxt;
      d_rdata  <= d_rdata_nxt;
    end
  end

  // Request fields and the byte assembly buffer carry no reset; they are always reloaded on grant
  always_ff @(posedge clk) begin
    if (grant) begin
      lat_port  <= eff_port;
      lat_addr  <= eff_addr;
      lat_we    <= eff_we;
      lat_err   <= eff_err;
      lat_n     <= eff_n;
      lat_wdata <= eff_wdata;
      rbuf      <= 32'd0;
    end else if (cap_now) begin
      rbuf <= rdata_new;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM with read latency, a cycle-indexed transaction
// model of expected outputs, directed scenarios and randomized traffic.
module tb_mem_arbiter;
  localparam int LAT  = 2;
  localparam int MAXC = 4096;
  localparam int BIG  = 1000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr;
  logic [1:0]  d_size;
  logic [31:0] d_wdata;
  logic        if_ack, d_ack, d_err, ram_wren, ram_rden, busy;
  logic [31:0] if_rdata, d_rdata;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data, ram_q;

  mem_arbiter #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_rden(ram_rden),
    .ram_data(ram_data), .ram_q(ram_q), .busy(busy)
  );

  always #5 clk = ~clk;

  // System RAM: byte array, read data appears LAT cycles after the address
  bit   [7:0]      mem [0:65535];
  logic [2:0][7:0] qp = '0;
  logic            poke_en = 1'b0;
  logic [15:0]     poke_addr = '0;
  logic [7:0]      poke_val = '0;
  int              cyc = 0;

  always @(posedge clk) begin
    if (poke_en)       mem[poke_addr] <= poke_val;
    else if (ram_wren) mem[ram_addr]  <= ram_data;
    qp <= {qp[1:0], (ram_rden ? mem[ram_addr] : 8'h00)};
  end
  assign ram_q = qp[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle
  bit   [7:0]  exp_mem [0:65535];
  bit          exp_busy [MAXC], exp_ifack [MAXC], exp_dack [MAXC], exp_derr [MAXC];
  bit          exp_rden [MAXC], exp_wren [MAXC];
  logic [15:0] exp_addr [MAXC];
  logic [7:0]  exp_data [MAXC];
  logic [31:0] exp_ifr [MAXC], exp_dr [MAXC];

  int checks = 0, errors = 0;
  int n_ifack = 0, n_dack = 0, last_ifack = -1, last_dack = -1, last_derr = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, expv);
    end
  endtask

  task automatic tick();
    int c;
    @(posedge clk);
    @(negedge clk);
    c = cyc;
    if (c >= MAXC) begin
      checks++;
      errors++;
      $display("FAIL cycle_budget at cycle %0d", c);
      return;
    end
    chk("busy",     {31'd0, busy},     {31'd0, exp_busy[c]});
    chk("if_ack",   {31'd0, if_ack},   {31'd0, exp_ifack[c]});
    chk("d_ack",    {31'd0, d_ack},    {31'd0, exp_dack[c]});
    chk("d_err",    {31'd0, d_err},    {31'd0, exp_derr[c]});
    chk("ram_rden", {31'd0, ram_rden}, {31'd0, exp_rden[c]});
    chk("ram_wren", {31'd0, ram_wren}, {31'd0, exp_wren[c]});
    chk("if_rdata", if_rdata, exp_ifr[c]);
    chk("d_rdata",  d_rdata,  exp_dr[c]);
    if (exp_rden[c] || exp_wren[c]) chk("ram_addr", {16'd0, ram_addr}, {16'd0, exp_addr[c]});
    if (exp_wren[c]) chk("ram_data", {24'd0, ram_data}, {24'd0, exp_data[c]});
    if (if_ack) begin n_ifack++; last_ifack = c; end
    if (d_ack)  begin n_dack++;  last_dack  = c; end
    if (d_err)  last_derr = c;
  endtask

  // Transaction granted in cycle t; events after 'cut' never happen (reset abort)
  function automatic int sched(input int t, input bit dport, input bit we, input logic [1:0] size,
                               input logic [15:0] addr, input logic [31:0] wdata, input int cut);
    bit          err   = dport && (size == 2'b11);
    bit          is_wr = dport && we && !err;
    int          n     = !dport ? 4 : (size == 2'b00 ? 1 : (size == 2'b01 ? 2 : 4));
    int          a;
    logic [15:0] ad;
    logic [31:0] val = 32'd0;
    if (err)        a = t + 1;
    else if (is_wr) a = t + n + 1;
    else            a = t + n + LAT + 1;
    if (!err) begin
      for (int k = 0; k < n; k++) begin
        int c = t + 1 + k;
        ad = addr + 16'(k);
        if (c <= cut && c < MAXC) begin
          exp_addr[c] = ad;
          if (is_wr) begin
            exp_wren[c] = 1'b1;
            exp_data[c] = wdata[8*k +: 8];
            exp_mem[ad] = wdata[8*k +: 8];
          end else begin
            exp_rden[c] = 1'b1;
            val[8*k +: 8] = exp_mem[ad];
          end
        end
      end
    end
    for (int c = t + 1; c <= a && c <= cut && c < MAXC; c++) exp_busy[c] = 1'b1;
    if (a <= cut && a < MAXC) begin
      if (dport) begin
        exp_dack[a] = 1'b1;
        exp_derr[a] = err;
      end else begin
        exp_ifack[a] = 1'b1;
      end
      if (!err && !is_wr)
        for (int c = a; c < MAXC; c++) begin
          if (dport) exp_dr[c] = val;
          else       exp_ifr[c] = val;
        end
    end
    return a;
  endfunction

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    poke_en = 1'b1; poke_addr = a; poke_val = v;
    exp_mem[a] = v;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic run_txn(input bit use_if, input bit use_d, input logic [15:0] ia, input bit we,
                         input logic [1:0] sz, input logic [15:0] da, input logic [31:0] wd,
                         output int t, output int ad, output int af);
    int last, gf;
    t = cyc; ad = -1; af = -1;
    if_req = use_if; if_addr = ia;
    d_req = use_d; d_we = we; d_size = sz; d_addr = da; d_wdata = wd;
    if (use_d) ad = sched(t, 1'b1, we, sz, da, wd, BIG);
    gf = use_d ? ad + 1 : t;
    if (use_if) af = sched(gf, 1'b0, 1'b0, 2'b10, ia, 32'd0, BIG);
    last = (ad > af) ? ad : af;
    while (cyc < last) begin
      tick();
      if (cyc == ad) d_req = 1'b0;
      if (cyc == af) if_req = 1'b0;
      if (use_d && cyc > t) begin
        d_we = 1'($urandom); d_size = 2'($urandom); d_addr = 16'($urandom); d_wdata = $urandom;
      end
      if (use_if && cyc > gf) if_addr = 16'($urandom);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 16'hFFFC + 16'($urandom_range(0, 3));
    return 16'h0400 + 16'($urandom_range(0, 31));
  endfunction

  initial begin
    int t, ad, af, b_if, b_d, r, kind, sz;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b00;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Fetch of a preloaded word
    poke(16'h0100, 8'h11); poke(16'h0101, 8'h22); poke(16'h0102, 8'h33); poke(16'h0103, 8'h44);
    tick();
    run_txn(1'b1, 1'b0, 16'h0100, 1'b0, 2'b00, 16'h0, 32'h0, t, ad, af);
    chk("fetch_rdata_lit", if_rdata, 32'h44332211);
    chk("fetch_ack_cycle", last_ifack, t + 7);

    // Word store then misaligned half load
    tick();
    run_txn(1'b0, 1'b1, 16'h0, 1'b1, 2'b10, 16'h0200, 32'hDEADBEEF, t, ad, af);
    chk("store_ack_cycle", last_dack, t + 5);
    chk("store_mem", {mem[16'h0203], mem[16'h0202], mem[16'h0201], mem[16'h0200]}, 32'hDEADBEEF);
    tick();
    run_txn(1'b0, 1'b1, 16'h0, 1'b0, 2'b01, 16'h0201, 32'h0, t, ad, af);
    chk("half_load_lit", d_rdata, 32'h0000ADBE);

    // Simultaneous requests: data first, then the pending fetch
    poke(16'h0010, 8'h5A);
    tick();
    b_if = n_ifack; b_d = n_dack;
    run_txn(1'b1, 1'b1, 16'h0100, 1'b0, 2'b00, 16'h0010, 32'h0, t, ad, af);
    chk("both_d_rdata", d_rdata, 32'h0000005A);
    chk("both_if_rdata", if_rdata, 32'h44332211);
    chk("both_d_first", {31'd0, last_dack < last_ifack}, 32'd1);
    chk("both_if_acks", n_ifack - b_if, 32'd1);
    chk("both_d_acks", n_dack - b_d, 32'd1);

    // Address wrap
    poke(16'hFFFE, 8'h01); poke(16'hFFFF, 8'h02); poke(16'h0000, 8'h03); poke(16'h0001, 8'h04);
    tick();
    run_txn(1'b0, 1'b1, 16'h0, 1'b0, 2'b10, 16'hFFFE, 32'h0, t, ad, af);
    chk("wrap_load_lit", d_rdata, 32'h04030201);

    // Illegal size
    tick();
    run_txn(1'b0, 1'b1, 16'h0, 1'b0, 2'b11, 16'h0500, 32'h0, t, ad, af);
    chk("err_ack_cycle", last_dack, t + 1);
    chk("err_flag_cycle", last_derr, t + 1);
    chk("err_rdata_kept", d_rdata, 32'h04030201);

    // Reset while the third byte of a word store would be issued
    tick();
    b_d = n_dack;
    t = cyc;
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 16'h0300; d_wdata = 32'hA1B2C3D4;
    ad = sched(t, 1'b1, 1'b1, 2'b10, 16'h0300, 32'hA1B2C3D4, t + 2);
    for (int c = t + 3; c < MAXC; c++) begin exp_ifr[c] = 32'd0; exp_dr[c] = 32'd0; end
    tick();
    tick();
    rst = 1'b0; d_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("abort_no_ack", n_dack - b_d, 32'd0);
    chk("abort_mem", {mem[16'h0303], mem[16'h0302], mem[16'h0301], mem[16'h0300]}, 32'h0000C3D4);

    // Randomized traffic
    for (int i = 0; i < 150 && cyc < MAXC - 60; i++) begin
      r = $urandom_range(0, 2);
      repeat (1 + r) tick();
      kind = $urandom_range(0, 3);
      sz = $urandom_range(0, 9);
      run_txn(kind == 0 || kind == 3, kind != 0, rand_addr(), 1'($urandom),
              (sz < 3) ? 2'(sz) : ((sz < 9) ? 2'b10 : 2'b11), rand_addr(), $urandom, t, ad, af);
    end
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
